// File: rtl/astable_555_vco_bank.sv
// Bank of independent 555-style astable oscillators sharing one ROM-based period evaluator.
// Each channel's high time tracks its control voltage; the low time is fixed by R2 and C.
module astable_555_vco_bank #(
    parameter int CHANNELS   = 4,
    parameter int CLOCK_RATE = 50000000,
    parameter int R1         = 47000,
    parameter int R2         = 27000,
    parameter int C_PF       = 33000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     audio_clk_en,
    input  logic [24*CHANNELS-1:0]   v_control,
    input  logic [CHANNELS-1:0]      reset_555_n,
    output logic [16*CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]      out_rise
);

    localparam int  CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam real C_F = real'(C_PF) * 1.0e-12;
    localparam real K   = real'(CLOCK_RATE) * C_F * real'(R1 + R2);

    function automatic logic [31:0] sat_round(input real r);
        if (r >= 4294967295.0) return 32'hFFFF_FFFF;
        if (r <= 0.0) return 32'd0;
        return 32'(longint'(r));
    endfunction

    // first = 1: charge from 0 to x*VCC; first = 0: charge from x/2*VCC to x*VCC
    function automatic logic [64*32-1:0] build_rom(input bit first);
        logic [64*32-1:0] rom;
        real              x;
        real              r;
        rom = '0;
        for (int i = 0; i < 64; i++) begin
            x = real'(i) / 64.0;
            if (first) r = K * $ln(1.0 / (1.0 - x));
            else       r = K * $ln((1.0 - x / 2.0) / (1.0 - x));
            rom[32*i +: 32] = sat_round(r);
        end
        return rom;
    endfunction

    localparam logic [31:0]        LOW_RAW   =
        sat_round(real'(CLOCK_RATE) * C_F * real'(R2) * $ln(2.0));
    localparam logic [31:0]        LOW_LEN   = (LOW_RAW == 32'd0) ? 32'd1 : LOW_RAW;
    localparam logic [64*32-1:0]   HIGH_ROM  = build_rom(1'b0);
    localparam logic [64*32-1:0]   FIRST_ROM = build_rom(1'b1);

    function automatic logic [31:0] interp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [9:0] frac);
        logic [41:0] prod;
        logic [31:0] y;
        prod = 42'(b - a) * 42'(frac);
        y    = a + prod[41:10];
        return (y == 32'd0) ? 32'd1 : y;
    endfunction

    // ---------------- shared evaluator ----------------
    logic [CW-1:0] ptr;
    logic [23:0]   vc_raw;
    logic [15:0]   vc;
    logic [5:0]    s0_idx;
    logic [9:0]    s0_frac;

    logic          s1_valid;
    logic [CW-1:0] s1_ch;
    logic [9:0]    s1_frac;
    logic [31:0]   s1_ha, s1_hb, s1_fa, s1_fb;

    logic [31:0]   shadow_high  [CHANNELS];
    logic [31:0]   shadow_first [CHANNELS];
    logic          seen_last;
    logic          shadow_valid;

    always_comb begin
        vc_raw = v_control[24*ptr +: 24];
        if (vc_raw < 24'd4096)       vc = 16'd4096;
        else if (vc_raw > 24'd61439) vc = 16'd61439;
        else                         vc = vc_raw[15:0];
        s0_idx  = vc[15:10];
        s0_frac = vc[9:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            s1_valid     <= 1'b0;
            s1_ch        <= '0;
            s1_frac      <= '0;
            s1_ha        <= '0;
            s1_hb        <= '0;
            s1_fa        <= '0;
            s1_fb        <= '0;
            seen_last    <= 1'b0;
            shadow_valid <= 1'b0;
            for (int n = 0; n < CHANNELS; n++) begin
                shadow_high[n]  <= '0;
                shadow_first[n] <= '0;
            end
        end else begin
            ptr      <= (ptr == CW'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
            s1_valid <= 1'b1;
            s1_ch    <= ptr;
            s1_frac  <= s0_frac;
            s1_ha    <= HIGH_ROM[32*s0_idx +: 32];
            s1_hb    <= HIGH_ROM[32*(s0_idx + 6'd1) +: 32];
            s1_fa    <= FIRST_ROM[32*s0_idx +: 32];
            s1_fb    <= FIRST_ROM[32*(s0_idx + 6'd1) +: 32];
            if (s1_valid) begin
                shadow_high[s1_ch]  <= interp(s1_ha, s1_hb, s1_frac);
                shadow_first[s1_ch] <= interp(s1_fa, s1_fb, s1_frac);
                if (s1_ch == CW'(CHANNELS - 1)) seen_last <= 1'b1;
            end
            // one extra clk so the last shadow write has settled before any channel starts
            shadow_valid <= seen_last;
        end
    end

    // ---------------- per-channel oscillators ----------------
    typedef enum logic [1:0] {StIdle, StFirstHigh, StHigh, StLow} state_e;

    state_e      state_q [CHANNELS];
    state_e      state_d [CHANNELS];
    logic [31:0] cnt_q   [CHANNELS];
    logic [31:0] cnt_d   [CHANNELS];
    logic [31:0] len_q   [CHANNELS];
    logic [31:0] len_d   [CHANNELS];
    logic        rise_d  [CHANNELS];
    logic [15:0] out_d   [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= '0;
            out_rise <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n] <= StIdle;
                cnt_q[n]   <= '0;
                len_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n]       <= state_d[n];
                cnt_q[n]         <= cnt_d[n];
                len_q[n]         <= len_d[n];
                out_rise[n]      <= rise_d[n];
                out[16*n +: 16]  <= out_d[n];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n] + 32'd1;
            len_d[n]   = len_q[n];
            rise_d[n]  = 1'b0;
            if (!reset_555_n[n]) begin
                state_d[n] = StIdle;
                cnt_d[n]   = '0;
            end else begin
                unique case (state_q[n])
                    StIdle: begin
                        cnt_d[n] = '0;
                        if (shadow_valid) begin
                            state_d[n] = StFirstHigh;
                            len_d[n]   = shadow_first[n];
                            rise_d[n]  = 1'b1;
                        end
                    end
                    StFirstHigh, StHigh: begin
                        if (cnt_q[n] == len_q[n] - 32'd1) begin
                            state_d[n] = StLow;
                            cnt_d[n]   = '0;
                        end
                    end
                    StLow: begin
                        if (cnt_q[n] == LOW_LEN - 32'd1) begin
                            state_d[n] = StHigh;
                            len_d[n]   = shadow_high[n];
                            cnt_d[n]   = '0;
                            rise_d[n]  = 1'b1;
                        end
                    end
                    default: begin
                        state_d[n] = StIdle;
                        cnt_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            out_d[n] = out[16*n +: 16];
            if (audio_clk_en) begin
                out_d[n] = (state_q[n] == StFirstHigh || state_q[n] == StHigh) ?
                           16'h8000 : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_astable_555_vco_bank.sv
// Scoreboard bench: stimulus queues expected phase lengths per channel, a monitor measures
// output run lengths and pops/compares them; a strobe phase checks sample-and-hold behaviour.
module tb_astable_555_vco_bank;

    localparam int CH = 4;

    logic              clk;
    logic              reset;
    logic              audio_clk_en;
    logic [24*CH-1:0]  v_control;
    logic [CH-1:0]     reset_555_n;
    logic [16*CH-1:0]  out;
    logic [CH-1:0]     out_rise;

    astable_555_vco_bank #(
        .CHANNELS   (CH),
        .CLOCK_RATE (1000000),
        .R1         (10000),
        .R2         (10000),
        .C_PF       (100000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .v_control    (v_control),
        .reset_555_n  (reset_555_n),
        .out          (out),
        .out_rise     (out_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit hi;
        int len;   // -1: any length, -2: startup gap of at least CH+3 clks
    } ph_t;

    int          total = 0;
    int          bad   = 0;
    ph_t         exp_q [CH][$];
    bit          lvl       [CH];
    int          run_len   [CH];
    bit          prev_rise [CH];
    int          rise_cyc  [CH];
    bit          rise_seen [CH];
    logic [15:0] last_s    [CH];
    int          hlen      [CH];
    int          vals      [CH];
    bit          strobe_mode = 1'b0;
    int          cyc = 0;
    int          low_len;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // K = f_clk*C*(R1+R2) = 2000 clks; periods follow the 555 charge equations sampled
    // at 64 points of the control voltage and linearly interpolated between them.
    function automatic int rom_point(input bit first, input int i);
        real k;
        real x;
        k = 1.0e6 * 100000.0e-12 * 20000.0;
        x = real'(i) / 64.0;
        if (first) return int'(k * $ln(1.0 / (1.0 - x)));
        return int'(k * $ln((1.0 - x / 2.0) / (1.0 - x)));
    endfunction

    function automatic int phase_len(input bit first, input int v);
        int c, i, f, a, b, y;
        c = (v < 4096) ? 4096 : (v > 61439) ? 61439 : v;
        i = c / 1024;
        f = c % 1024;
        a = rom_point(first, i);
        b = rom_point(first, i + 1);
        y = a + ((b - a) * f) / 1024;
        return (y < 1) ? 1 : y;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic finish_run(input int n, input bit hi, input int length);
        if (exp_q[n].size() > 0) begin
            ph_t e;
            e = exp_q[n].pop_front();
            check($sformatf("ch%0d phase level", n), int'(hi), int'(e.hi));
            if (e.len == -2)
                check($sformatf("ch%0d startup gap>=%0d (len %0d)", n, CH + 3, length),
                      int'(length >= CH + 3), 1);
            else if (e.len >= 0)
                check($sformatf("ch%0d %s length", n, e.hi ? "high" : "low"), length, e.len);
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < CH; n++) begin
            logic [15:0] s;
            bit          hi;
            bit          rose;
            s    = out[16*n +: 16];
            hi   = (s == 16'h8000);
            rose = hi && !lvl[n];
            if (reset) begin
                lvl[n]     = 1'b0;
                run_len[n] = 0;
            end else if (!strobe_mode) begin
                if (prev_rise[n] || rose)
                    check($sformatf("ch%0d out_rise precedes high", n),
                          int'(prev_rise[n]), int'(rose));
                if (s != 16'h0000 && s != 16'h8000)
                    check($sformatf("ch%0d legal out value", n), int'(s), 0);
                if (hi != lvl[n]) begin
                    finish_run(n, lvl[n], run_len[n]);
                    lvl[n]     = hi;
                    run_len[n] = 1;
                end else begin
                    run_len[n]++;
                end
            end else if (rise_seen[n]) begin
                logic [15:0] want;
                if (audio_clk_en)
                    want = ((cyc - 1 - rise_cyc[n]) < hlen[n]) ? 16'h8000 : 16'h0000;
                else
                    want = last_s[n];
                check($sformatf("ch%0d strobe en=%0d out", n, audio_clk_en), int'(s), int'(want));
            end
            last_s[n]    = s;
            prev_rise[n] = out_rise[n];
            if (!reset && out_rise[n]) begin
                rise_cyc[n]  = cyc;
                rise_seen[n] = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_v(input int n, input int v);
        v_control[24*n +: 24] = v[23:0];
        vals[n] = v;
    endtask

    task automatic push(input int n, input bit hi, input int len);
        ph_t e;
        e.hi  = hi;
        e.len = len;
        exp_q[n].push_back(e);
    endtask

    task automatic push_cycle(input int n, input int v, input int highs);
        push(n, 1'b1, phase_len(1'b1, v));
        push(n, 1'b0, low_len);
        for (int j = 0; j < highs; j++) begin
            push(n, 1'b1, phase_len(1'b0, v));
            push(n, 1'b0, low_len);
        end
    endtask

    function automatic bit all_empty();
        for (int n = 0; n < CH; n++) if (exp_q[n].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (k < budget && !all_empty()) begin
            @(negedge clk);
            k++;
        end
        check({name, " scoreboard drained"}, int'(all_empty()), 1);
    endtask

    task automatic wait_size(input int n, input int sz, input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (k < budget && exp_q[n].size() != sz);
        check({name, " reached"}, int'(exp_q[n].size() == sz), 1);
    endtask

    task automatic pulse_reset(input logic [CH-1:0] pin4);
        @(negedge clk);
        #1;
        reset = 1'b1;
        reset_555_n = pin4;
        #1;
        check("async reset clears out", int'(out != '0), 0);
        check("async reset clears out_rise", int'(out_rise), 0);
        for (int n = 0; n < CH; n++) exp_q[n].delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int k;
        low_len      = int'(1.0e6 * 100000.0e-12 * 10000.0 * $ln(2.0));
        reset        = 1'b1;
        audio_clk_en = 1'b1;
        reset_555_n  = '0;
        v_control    = '0;
        for (int n = 0; n < CH; n++) begin
            vals[n] = 0;
            hlen[n] = 1;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset out", int'(out != '0), 0);
        check("reset out_rise", int'(out_rise), 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("pin4 held low keeps out idle", int'(out != '0), 0);

        // nominal 2/3 VCC, both clamp extremes, one random voltage
        set_v(0, 43691);
        set_v(1, 0);
        set_v(2, 24'hFFFFFF);
        set_v(3, int'($urandom & 32'h00FF_FFFF));
        pulse_reset('1);
        for (int n = 0; n < CH; n++) begin
            push(n, 1'b0, -2);
            push_cycle(n, vals[n], 2);
        end
        wait_drain(40000, "basic");

        // mid-high voltage change on ch0, mid-low pin4 pulse on ch2
        set_v(0, 43691);
        for (int n = 1; n < CH; n++) set_v(n, int'($urandom & 32'h00FF_FFFF));
        pulse_reset('1);
        push(0, 1'b0, -2);
        push(0, 1'b1, phase_len(1'b1, 43691));
        push(0, 1'b0, low_len);
        push(0, 1'b1, phase_len(1'b0, 43691));
        push(1, 1'b0, -2);
        push_cycle(1, vals[1], 1);
        push(3, 1'b0, -2);
        push_cycle(3, vals[3], 1);
        push(2, 1'b0, -2);
        push(2, 1'b1, phase_len(1'b1, vals[2]));
        fork
            begin
                wait_size(0, 1, 10000, "ch0 in high");
                repeat (100) @(negedge clk);
                #1;
                set_v(0, 21845);
                push(0, 1'b0, low_len);
                push(0, 1'b1, phase_len(1'b0, 21845));
                push(0, 1'b0, low_len);
                push(0, 1'b1, phase_len(1'b0, 21845));
                push(0, 1'b0, low_len);
            end
            begin
                wait_size(2, 0, 10000, "ch2 in low");
                push(2, 1'b0, -1);
                push_cycle(2, vals[2], 1);
                repeat (50) @(negedge clk);
                #1;
                reset_555_n[2] = 1'b0;
                @(negedge clk);
                #1;
                reset_555_n[2] = 1'b1;
            end
        join
        wait_drain(40000, "update and pin4");

        // global reset while ch0 is high
        k = 0;
        while (k < 10000 && out[15:0] != 16'h8000) begin
            @(negedge clk);
            k++;
        end
        check("ch0 high before reset", int'(out[15:0]), 32'h8000);
        repeat (10) @(negedge clk);
        for (int n = 0; n < CH; n++) set_v(n, int'($urandom_range(20000, 50000)));
        pulse_reset('1);
        for (int n = 0; n < CH; n++) begin
            hlen[n] = phase_len(1'b0, vals[n]);
            push(n, 1'b0, -2);
            push_cycle(n, vals[n], 1);
        end
        wait_drain(40000, "restart");

        // 1-in-20 sample strobe
        @(negedge clk);
        #1;
        strobe_mode = 1'b1;
        for (int j = 0; j < 3000; j++) begin
            audio_clk_en = (j % 20 == 0);
            @(negedge clk);
            #1;
        end
        strobe_mode  = 1'b0;
        audio_clk_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
